// File: rtl/aes_uart_pkg.sv
// Shared definitions for the cipher UART streamer: FSM state encodings,
// ASCII constants used by the optional hex formatter, the default baud
// divisor, and a nibble-to-ASCII helper.
package aes_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    // 10 MHz clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_A_LOWER = 8'h61;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;

    // Lower-case ASCII hex digit for a 4-bit value
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = ASCII_ZERO + {4'd0, nib};
        end else begin
            res = ASCII_A_LOWER + {4'd0, nib - 4'd10};
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 bit serializer: START, DATA (LSB first) and STOP, each bit held for
// CLKS_PER_BIT cycles. A byte is taken when valid is high while idle; the
// start bit appears on tx in the following cycle. done is high in the last
// cycle of the stop bit.
module uart_tx_byte
    import aes_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_reg;
    logic          bit_end;

    assign bit_end = (baud == BAUD_MAX);
    assign ready   = (state == ST_IDLE);
    assign done    = (state == ST_STOP) && bit_end;
    assign tx      = tx_reg;

    // Bit-phase state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit-phase transitions
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (valid) state_next = ST_START;
                else       state_next = ST_IDLE;
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
                else         state_next = ST_START;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) state_next = ST_STOP;
                else                              state_next = ST_DATA;
            end
            ST_STOP: begin
                if (bit_end) state_next = ST_IDLE;
                else         state_next = ST_STOP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Baud counter, bit counter, shifter and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx_reg  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud    <= '0;
                    bit_idx <= 3'd0;
                    if (valid) begin
                        shift  <= data;
                        tx_reg <= 1'b0;
                    end else begin
                        tx_reg <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud   <= '0;
                        tx_reg <= shift[0];
                    end else begin
                        baud   <= baud + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            tx_reg  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx_reg  <= shift[1];
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                ST_STOP: begin
                    tx_reg <= 1'b1;
                    if (bit_end) baud <= '0;
                    else         baud <= baud + CW'(1);
                end
                default: begin
                    baud   <= '0;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/cipher_uart_streamer.sv
// Streams a captured cipher block out over a UART 8N1 line, one character
// per byte (raw) or, with CIPHER_UART_HEX_ASCII_EN defined, two lower-case
// hex digits per byte followed by CR LF. This block owns the handshake,
// block capture, character sequencing and the one-cycle NEXT gap; the
// uart_tx_byte instance produces the START/DATA/STOP bit phases. While a
// character is with the serializer this sequencer waits in ST_START.
module cipher_uart_streamer
    import aes_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int BLOCK_BITS   = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:BLOCK_BITS-1] i_block,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_uart_tx,
    output logic                  o_busy,
    output logic                  o_done
);

`ifdef CIPHER_UART_HEX_ASCII_EN
    localparam int NUM_CHARS = BLOCK_BITS / 4 + 2;
`else
    localparam int NUM_CHARS = BLOCK_BITS / 8;
`endif
    localparam int IW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IW-1:0] LAST_CHAR = IW'(NUM_CHARS - 1);

    // Character number idx of block blk as it appears on the line
    function automatic logic [7:0] char_at(input logic [0:BLOCK_BITS-1] blk,
                                           input logic [IW-1:0]         idx);
        logic [7:0] res;
`ifdef CIPHER_UART_HEX_ASCII_EN
        logic [3:0] nib;
        nib = 4'h0;
        if (int'(idx) < BLOCK_BITS / 4) begin
            nib = blk[4*idx +: 4];
            res = hex_ascii(nib);
        end else if (int'(idx) == BLOCK_BITS / 4) begin
            res = ASCII_CR;
        end else begin
            res = ASCII_LF;
        end
`else
        res = blk[8*idx +: 8];
`endif
        return res;
    endfunction

    state_t                seq_state;
    state_t                seq_next;
    logic [0:BLOCK_BITS-1] block_q;
    logic [IW-1:0]         char_idx;
    logic [0:BLOCK_BITS-1] src_block;
    logic [IW-1:0]         src_idx;
    logic                  ser_valid;
    logic                  ser_ready;
    logic                  ser_tx;
    logic                  ser_done;
    logic [7:0]            ser_data;
    logic                  last_char;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;

    assign last_char = (char_idx == LAST_CHAR);
    assign ser_data  = char_at(src_block, src_idx);
    assign o_ready   = ready_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_uart_tx = ser_tx;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (ser_data),
        .valid (ser_valid),
        .ready (ser_ready),
        .tx    (ser_tx),
        .done  (ser_done)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_state <= ST_IDLE;
        end else begin
            seq_state <= seq_next;
        end
    end

    // Sequencer transitions and serializer launch; the first character is
    // taken straight from i_block so its start bit follows the handshake
    always_comb begin
        seq_next  = seq_state;
        ser_valid = 1'b0;
        src_block = block_q;
        src_idx   = '0;
        case (seq_state)
            ST_IDLE: begin
                src_block = i_block;
                ser_valid = i_valid;
                if (i_valid) seq_next = ST_START;
                else         seq_next = ST_IDLE;
            end
            ST_START: begin
                if (ser_done) seq_next = ST_NEXT;
                else          seq_next = ST_START;
            end
            ST_NEXT: begin
                if (last_char) begin
                    seq_next = ST_IDLE;
                end else if (ser_ready) begin
                    src_idx   = char_idx + IW'(1);
                    ser_valid = 1'b1;
                    seq_next  = ST_START;
                end else begin
                    seq_next = ST_NEXT;
                end
            end
            default: seq_next = ST_IDLE;
        endcase
    end

    // Block capture and character counter
    always_ff @(posedge clk) begin
        if (rst) begin
            block_q  <= '0;
            char_idx <= '0;
        end else if ((seq_state == ST_IDLE) && i_valid) begin
            block_q  <= i_block;
            char_idx <= '0;
        end else if ((seq_state == ST_NEXT) && (seq_next == ST_START)) begin
            char_idx <= char_idx + IW'(1);
        end else if (seq_next == ST_IDLE) begin
            char_idx <= '0;
        end else begin
            char_idx <= char_idx;
        end
    end

    // Registered status outputs; o_done covers the NEXT cycle of the last character
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (seq_next == ST_IDLE);
            busy_q  <= (seq_next != ST_IDLE);
            done_q  <= (seq_state == ST_START) && ser_done && last_char;
        end
    end

endmodule

// File: tb/tb_cipher_uart_streamer.sv
// Self-checking bench for cipher_uart_streamer (CLKS_PER_BIT=4, BLOCK_BITS=128).
// A behavioural model turns each accepted block into the expected per-cycle
// line/status sequence; one compare process checks every cycle.
module tb_cipher_uart_streamer;

    localparam int C  = 4;
    localparam int BB = 128;
`ifdef CIPHER_UART_HEX_ASCII_EN
    localparam int   NCH       = 34;
    localparam int   LAT       = 1394;
    localparam logic FIRST_BIT = 1'b0;
`else
    localparam int   NCH       = 16;
    localparam int   LAT       = 656;
    localparam logic FIRST_BIT = 1'b1;
`endif
    localparam logic [0:BB-1] KNOWN = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [0:BB-1] i_block = '0;
    logic          o_ready, o_uart_tx, o_busy, o_done;

    int   checks = 0;
    int   errors = 0;
    logic exp_tx[$];
    logic exp_done[$];
    logic m_ready = 1'b1;
    logic armed = 1'b0;
    int   cyc = 0;
    int   hs_last = 0;
    int   hs_prev = 0;

    cipher_uart_streamer #(.CLKS_PER_BIT(C), .BLOCK_BITS(BB)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_block   (i_block),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_uart_tx (o_uart_tx),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Character k of a block as numbers: byte k is bits 8k..8k+7 counted from the MSB
    function automatic logic [7:0] model_char(input logic [0:BB-1] blk, input int k);
        logic [127:0] v;
        int nib;
        v = blk;
`ifdef CIPHER_UART_HEX_ASCII_EN
        if (k < 32) begin
            nib = int'((v >> (124 - 4*k)) & 128'hF);
            return (nib < 10) ? 8'(48 + nib) : 8'(87 + nib);
        end else if (k == 32) begin
            return 8'h0D;
        end else begin
            return 8'h0A;
        end
`else
        nib = 0;
        return 8'((v >> (120 - 8*k)) & 128'hFF);
`endif
    endfunction

    // Expected line level and done flag for every cycle of one block
    function automatic void push_frame(input logic [0:BB-1] blk);
        logic [7:0] c;
        for (int k = 0; k < NCH; k++) begin
            c = model_char(blk, k);
            for (int i = 0; i < 10*C; i++) begin
                if (i < C)        exp_tx.push_back(1'b0);
                else if (i < 9*C) exp_tx.push_back(c[(i - C) / C]);
                else              exp_tx.push_back(1'b1);
                exp_done.push_back(1'b0);
            end
            exp_tx.push_back(1'b1);
            exp_done.push_back(k == NCH - 1);
        end
    endfunction

    function automatic logic [0:BB-1] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Model: reset flushes, a handshake queues the whole frame
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_tx.delete();
            exp_done.delete();
            armed = 1'b1;
        end else if (armed && i_valid && m_ready) begin
            push_frame(i_block);
            hs_prev = hs_last;
            hs_last = cyc;
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        logic etx, edone, erdy;
        if (armed) begin
            if (exp_tx.size() > 0) begin
                etx   = exp_tx.pop_front();
                edone = exp_done.pop_front();
                erdy  = 1'b0;
            end else begin
                etx   = 1'b1;
                edone = 1'b0;
                erdy  = 1'b1;
            end
            m_ready = erdy;
            check("cycle{tx,ready,busy,done}", {28'd0, o_uart_tx, o_ready, o_busy, o_done},
                  {28'd0, etx, erdy, ~erdy, edone});
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (o_ready !== 1'b1 && n < 2*LAT + 10) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic send_timed(input logic [0:BB-1] blk, input bit pin_first);
        int n = 0;
        wait_ready();
        i_valid = 1'b1;
        i_block = blk;
        @(negedge clk);
        i_valid = 1'b0;
        i_block = rand_block();
        while (n < LAT + 20 && o_done !== 1'b1) begin
            if (n < C) check("start_bit", {31'd0, o_uart_tx}, 32'd0);
            if (pin_first && n == C) check("first_data_bit", {31'd0, o_uart_tx}, {31'd0, FIRST_BIT});
            @(negedge clk);
            n++;
        end
        check("done_latency", n + 1, LAT);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dn, n;
        // Reset with i_valid high: reset must win
        rst = 1'b1; i_valid = 1'b1; i_block = KNOWN;
        repeat (3) @(negedge clk);
        check("reset_tx",    {31'd0, o_uart_tx}, 32'd1);
        check("reset_ready", {31'd0, o_ready},   32'd1);
        check("reset_busy",  {31'd0, o_busy},    32'd0);
        check("reset_done",  {31'd0, o_done},    32'd0);
        rst = 1'b0; i_valid = 1'b0;

        // Pin the model with hand-computed characters
`ifdef CIPHER_UART_HEX_ASCII_EN
        check("model_char0",  {24'd0, model_char(KNOWN, 0)},  32'h36);
        check("model_char1",  {24'd0, model_char(KNOWN, 1)},  32'h39);
        check("model_char31", {24'd0, model_char(KNOWN, 31)}, 32'h61);
        check("model_char33", {24'd0, model_char(KNOWN, 33)}, 32'h0A);
`else
        check("model_char0",  {24'd0, model_char(KNOWN, 0)},  32'h69);
        check("model_char1",  {24'd0, model_char(KNOWN, 1)},  32'hc4);
        check("model_char15", {24'd0, model_char(KNOWN, 15)}, 32'h5a);
`endif

        // Known block with timing pins
        send_timed(KNOWN, 1'b1);

        // i_valid held with a changing block: two frames, second one cycle after done
        wait_ready();
        i_valid = 1'b1;
        dn = 0; n = 0;
        while (dn < 2 && n < 3*LAT) begin
            i_block = rand_block();
            @(negedge clk);
            n++;
            if (o_done === 1'b1) dn++;
        end
        i_valid = 1'b0;
        check("busy_done_count", dn, 2);
        check("busy_rehandshake_gap", hs_last - hs_prev, LAT + 1);

        // Reset in the middle of data bit 3 of byte 5, with i_valid high
        wait_ready();
        i_valid = 1'b1; i_block = rand_block();
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5*(10*C + 1) + C + 3*C) @(negedge clk);
        rst = 1'b1; i_valid = 1'b1;
        @(negedge clk);
        check("midreset_tx",    {31'd0, o_uart_tx}, 32'd1);
        check("midreset_ready", {31'd0, o_ready},   32'd1);
        check("midreset_done",  {31'd0, o_done},    32'd0);
        rst = 1'b0; i_valid = 1'b0;
        send_timed(rand_block(), 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            i_valid = ($urandom_range(0, 11) == 0);
            i_block = rand_block();
            rst     = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; i_valid = 1'b0;
        wait_ready();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
